// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. A single full-add cell (two half adders plus
//   an OR for the carry) is time-shared over WIDTH clock cycles. It adds two
//   WIDTH-bit unsigned operands LSB first.
//
//   Ports
//     clk    in   rising-edge clock
//     rst    in   asynchronous, active-high reset
//     start  in   request, sampled only while IDLE
//     a, b   in   WIDTH-bit operands, captured on an accepted start
//     busy   out  high while the serial add is running (ADD)
//     done   out  one-cycle pulse, sum/cout valid
//     sum    out  registered WIDTH-bit result
//     cout   out  registered final carry (unsigned overflow)
//
//   Timing: start sampled at edge E0, ADD runs for edges E1..EWIDTH.
//   done is high between EWIDTH and EWIDTH+1. Back-to-back period is
//   WIDTH+2 edges, because start is ignored in DONE.
// ---------------------------------------------------------------------------

// Half adder: s = a ^ b, c = a & b.
module halfadder (
   input  logic a,
   input  logic b,
   output logic c,
   output logic s
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // 2'b11 is unused and falls back to IDLE through the default arm.
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_ADD  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   // Shared full-add cell
   logic s0, c0, bit_s, c1, cell_carry;

   halfadder u_ha0 (
      .a (a_sr_q[0]),
      .b (b_sr_q[0]),
      .c (c0),
      .s (s0)
   );

   halfadder u_ha1 (
      .a (s0),
      .b (carry_q),
      .c (c1),
      .s (bit_s)
   );

   assign cell_carry = c0 | c1;

   // ---------------------------------------------------------------------
   // State register and datapath flops
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = start ? S_ADD : S_IDLE;
         S_ADD:   state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------------
   always_comb begin
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               res_sr_d = '0;
               carry_d  = 1'b0;
               cnt_d    = '0;
            end
         end
         S_ADD: begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            res_sr_d = {bit_s, res_sr_q[WIDTH-1:1]};
            carry_d  = cell_carry;
            cnt_d    = cnt_q + CW'(1);
            // The visible result only updates once, with the full word,
            // so sum never exposes a partially shifted value.
            if (cnt_q == CNT_LAST) begin
               sum_d  = {bit_s, res_sr_q[WIDTH-1:1]};
               cout_d = cell_carry;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      busy = (state_q == S_ADD);
      done = (state_q == S_DONE);
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=4). Expected results are
// queued when an operation is launched and popped when done pulses.
module tb_serial_add_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int overlap  = 0;
   logic [W:0] sb_q[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy && done) overlap++;

   // Launch one operation: start for one sampled edge, optionally record
   // the expected result. Returns at the first negedge after the start edge.
   task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      @(negedge clk);
      start = 1'b1; a = x; b = y;
      if (push) sb_q.push_back({1'b0, x} + {1'b0, y});
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   // Bounded wait for done; reports negedges waited and busy cycles seen.
   task automatic wait_done(output int cyc, output int nbusy);
      cyc = 0; nbusy = 0;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      int cyc, nb;
      logic [W:0] e;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #12;
      chk_cnt++;
      if ({busy, done, cout, sum} !== '0)
         $display("FAIL reset_state: got %b exp 0", {busy, done, cout, sum});
      else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      // get a nonzero result on sum first
      drive_op(4'd7, 4'd6, 1'b1);
      wait_done(cyc, nb);
      e = sb_q.size() ? sb_q.pop_front() : '1;
      chk_cnt++;
      if (cyc >= 40 || {cout, sum} !== e)
         $display("FAIL pre_reset_op: got %h exp %h (cyc %0d)", {cout, sum}, e, cyc);
      else pass_cnt++;
      // async reset in the middle of ADD
      drive_op(4'd2, 4'd1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({busy, done, cout, sum} !== '0)
         $display("FAIL async_reset_mid_add: got %b exp 0", {busy, done, cout, sum});
      else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({busy, done} !== 2'b00)
         $display("FAIL idle_after_reset: busy/done %b exp 00", {busy, done});
      else pass_cnt++;
   endtask

   task automatic test_basic;
      int cyc, nb;
      logic [W:0] e;
      drive_op(4'd3, 4'd5, 1'b1);
      wait_done(cyc, nb);
      chk_cnt++;
      if (cyc !== 4) $display("FAIL basic_done_latency: got %0d exp 4", cyc);
      else pass_cnt++;
      chk_cnt++;
      if (nb !== 4) $display("FAIL basic_busy_cycles: got %0d exp 4", nb);
      else pass_cnt++;
      e = sb_q.size() ? sb_q.pop_front() : '1;
      chk_cnt++;
      if ({cout, sum} !== e) $display("FAIL basic_result: got %h exp %h", {cout, sum}, e);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b0 || sum !== 4'd8)
         $display("FAIL basic_done_pulse_hold: done %b sum %h exp done 0 sum 8", done, sum);
      else pass_cnt++;
      // while the next add runs, sum must keep the previous result
      drive_op(4'd1, 4'd1, 1'b1);
      @(negedge clk);
      chk_cnt++;
      if (sum !== 4'd8 || cout !== 1'b0)
         $display("FAIL sum_stable_during_add: got %h exp 08", {cout, sum});
      else pass_cnt++;
      wait_done(cyc, nb);
      e = sb_q.size() ? sb_q.pop_front() : '1;
      chk_cnt++;
      if (cyc >= 40 || {cout, sum} !== e) $display("FAIL basic_second: got %h exp %h", {cout, sum}, e);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_wrap;
      logic [W-1:0] xs[3] = '{4'd15, 4'd15, 4'd0};
      logic [W-1:0] ys[3] = '{4'd1, 4'd15, 4'd0};
      logic [W:0]   ex[3] = '{5'h10, 5'h1e, 5'h00};
      int cyc, nb;
      logic [W:0] e;
      for (int i = 0; i < 3; i++) begin
         drive_op(xs[i], ys[i], 1'b1);
         wait_done(cyc, nb);
         e = sb_q.size() ? sb_q.pop_front() : '1;
         chk_cnt++;
         if (cyc >= 40 || {cout, sum} !== e || e !== ex[i])
            $display("FAIL wrap_%0d: got %h exp %h", i, {cout, sum}, ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   // start held high, operands changing every cycle; DUT samples every 6 edges
   task automatic test_start_held;
      logic [W:0] e;
      for (int i = 0; i < 30; i++) begin
         if (i >= 5 && (i % 6) == 5) begin
            e = sb_q.size() ? sb_q.pop_front() : '1;
            chk_cnt++;
            if (done !== 1'b1 || {cout, sum} !== e)
               $display("FAIL held_result_%0d: done %b got %h exp %h", i, done, {cout, sum}, e);
            else pass_cnt++;
         end else begin
            chk_cnt++;
            if (done !== 1'b0) $display("FAIL held_no_done_%0d: done %b exp 0", i, done);
            else pass_cnt++;
         end
         start = 1'b1; a = W'($urandom); b = W'($urandom);
         if ((i % 6) == 0) sb_q.push_back({1'b0, a} + {1'b0, b});
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (sb_q.size() !== 0 || busy !== 1'b0)
         $display("FAIL held_drain: queue %0d busy %b exp 0 0", sb_q.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_abort;
      int cyc, nb, ndone;
      logic [W:0] e;
      drive_op(4'd9, 4'd4, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({busy, done} !== 2'b00) $display("FAIL abort_async: busy/done %b exp 00", {busy, done});
      else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk_cnt++;
      if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses exp 0", ndone);
      else pass_cnt++;
      drive_op(4'd6, 4'd7, 1'b1);
      wait_done(cyc, nb);
      e = sb_q.size() ? sb_q.pop_front() : '1;
      chk_cnt++;
      if (cyc !== 4 || {cout, sum} !== e || e !== 5'h0d)
         $display("FAIL abort_next_op: got %h cyc %0d exp 0d cyc 4", {cout, sum}, cyc);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_exhaustive;
      int cyc, nb, nfail;
      logic [W:0] e;
      nfail = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            drive_op(W'(x), W'(y), 1'b1);
            wait_done(cyc, nb);
            e = sb_q.size() ? sb_q.pop_front() : '1;
            chk_cnt++;
            if (cyc >= 40 || {cout, sum} !== e || e !== 5'(x + y)) begin
               nfail++;
               if (nfail < 10)
                  $display("FAIL exhaustive %0d+%0d: got %h exp %h", x, y, {cout, sum}, 5'(x + y));
            end else pass_cnt++;
            @(negedge clk);
         end
      end
      chk_cnt++;
      if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d exp 0", overlap);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_start_held();
      test_abort();
      test_exhaustive();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
